// File: rtl/pulse_burst_ctrl.sv
// Programmable pulse-burst scheduler driving the BPSK modulator transmit gate.
// Optional macro PULSE_SYNC_EN adds sync_in and an ARM state that waits for its rising edge.
module pulse_burst_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] cfg_on,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [NUM_W-1:0] cfg_num,
`ifdef PULSE_SYNC_EN
  input  logic             sync_in,
`endif
  output logic             busy,
  output logic             gate,
  output logic             pulse_start,
  output logic [NUM_W-1:0] pulse_idx,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [NUM_W-1:0] NumOne = NUM_W'(1);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StFinish} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] on_q, on_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0] idx_q, idx_d;
  logic             gate_q, gate_d;
  logic             pulse_start_q, pulse_start_d;
  logic             cfg_err_q, cfg_err_d;

  logic             cfg_bad;
  logic             last_phase;
  logic             last_pulse;
  logic [CNT_W-1:0] phase_inc;

`ifdef PULSE_SYNC_EN
  logic sync_q;
  logic sync_rise;

  assign sync_rise = sync_in && !sync_q;
`endif

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    on_d          = on_q;
    period_d      = period_q;
    num_d         = num_q;
    idx_d         = idx_q;
    gate_d        = 1'b0;
    pulse_start_d = 1'b0;
    cfg_err_d     = 1'b0;

    // on < period is enforced at start, so period-1 and on compares never wrap.
    cfg_bad    = (cfg_on == '0) || (cfg_on >= cfg_period);
    phase_inc  = phase_q + CntOne;
    last_phase = (phase_q == (period_q - CntOne));
    last_pulse = (num_q != '0) && ((idx_q + NumOne) == num_q);

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          on_d     = cfg_on;
          period_d = cfg_period;
          num_d    = cfg_num;
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            idx_d   = '0;
            phase_d = '0;
`ifdef PULSE_SYNC_EN
            state_d = StArm;
`else
            state_d       = StRun;
            gate_d        = 1'b1;
            pulse_start_d = 1'b1;
`endif
          end
        end
      end
`ifdef PULSE_SYNC_EN
      StArm: begin
        if (stop) begin
          state_d = StIdle;
        end else if (sync_rise) begin
          state_d       = StRun;
          phase_d       = '0;
          gate_d        = 1'b1;
          pulse_start_d = 1'b1;
        end
      end
`endif
      StRun: begin
        if (stop) begin
          state_d = StIdle;
          phase_d = '0;
        end else if (last_phase) begin
          phase_d = '0;
          if (last_pulse) begin
            state_d = StFinish;
          end else begin
            idx_d         = idx_q + NumOne;
            gate_d        = 1'b1;
            pulse_start_d = 1'b1;
          end
        end else begin
          phase_d = phase_inc;
          gate_d  = (phase_inc < on_q);
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      phase_q       <= '0;
      on_q          <= '0;
      period_q      <= '0;
      num_q         <= '0;
      idx_q         <= '0;
      gate_q        <= 1'b0;
      pulse_start_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      on_q          <= on_d;
      period_q      <= period_d;
      num_q         <= num_d;
      idx_q         <= idx_d;
      gate_q        <= gate_d;
      pulse_start_q <= pulse_start_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

`ifdef PULSE_SYNC_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= sync_in;
    end
  end
`endif

  assign busy        = (state_q == StRun) || (state_q == StArm);
  assign done        = (state_q == StFinish);
  assign gate        = gate_q;
  assign pulse_start = pulse_start_q;
  assign pulse_idx   = idx_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Self-checking bench for pulse_burst_ctrl; expected output vectors are queued per cycle.
// The ARM-state scenario is built only when PULSE_SYNC_EN is defined.
module tb_pulse_burst_ctrl;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned NUM_W = 8;

  // {busy, gate, pulse_start, done, cfg_err, pulse_idx}
  typedef logic [12:0] vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] cfg_on;
  logic [CNT_W-1:0] cfg_period;
  logic [NUM_W-1:0] cfg_num;
  logic             sync_in;
  logic             busy;
  logic             gate;
  logic             pulse_start;
  logic [NUM_W-1:0] pulse_idx;
  logic             done;
  logic             cfg_err;

  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pulse_burst_ctrl #(
    .CNT_W(CNT_W),
    .NUM_W(NUM_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .cfg_on     (cfg_on),
    .cfg_period (cfg_period),
    .cfg_num    (cfg_num),
`ifdef PULSE_SYNC_EN
    .sync_in    (sync_in),
`endif
    .busy       (busy),
    .gate       (gate),
    .pulse_start(pulse_start),
    .pulse_idx  (pulse_idx),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic b, input logic g, input logic p, input logic d,
                              input logic e, input logic [NUM_W-1:0] i);
    return {b, g, p, d, e, i};
  endfunction

  function automatic vec_t obs();
    return {busy, gate, pulse_start, done, cfg_err, pulse_idx};
  endfunction

  task automatic test_reset();
    vec_t ex, got;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
      tick();
      ex = exp_q.pop_front();
      got = obs();
      n_checks++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL reset k=%0d got=%b required=%b", k, got, ex);
      end
    end
    rst = 1'b1;
  endtask

  // on=3 period=10 num=2: gate 1-3 and 11-13, done at 21
  task automatic test_basic_burst();
    vec_t ex, got;
    int   p;
    cfg_on = 16'd3; cfg_period = 16'd10; cfg_num = 8'd2; start = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      p = (k - 1) % 10;
      if (k <= 20) exp_q.push_back(mk(1'b1, p < 3, p == 0, 1'b0, 1'b0, 8'((k - 1) / 10)));
      else         exp_q.push_back(mk(1'b0, 1'b0, 1'b0, k == 21, 1'b0, 8'd1));
      tick();
      start = 1'b0;
      ex = exp_q.pop_front();
      got = obs();
      n_checks++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL basic_burst k=%0d got=%b required=%b", k, got, ex);
      end
    end
  endtask

  task automatic test_cfg_err();
    vec_t             ex, got;
    logic [CNT_W-1:0] ons [3];
    ons = '{16'd10, 16'd0, 16'd11};
    for (int i = 0; i < 3; i++) begin
      cfg_on = ons[i]; cfg_period = 16'd10; cfg_num = 8'd2; start = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
      for (int k = 0; k < 2; k++) begin
        tick();
        start = 1'b0;
        ex = exp_q.pop_front();
        got = obs();
        n_checks++;
        if (got !== ex) begin
          n_fail++;
          $display("FAIL cfg_err on=%0d k=%0d got=%b required=%b", ons[i], k, got, ex);
        end
      end
    end
    // start and stop together: stop wins, nothing starts
    cfg_on = 16'd3; start = 1'b1; stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
      tick();
      start = 1'b0; stop = 1'b0;
      ex = exp_q.pop_front();
      got = obs();
      n_checks++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL start_stop k=%0d got=%b required=%b", k, got, ex);
      end
    end
  endtask

  task automatic test_continuous();
    vec_t ex, got;
    int   p;
    cfg_on = 16'd1; cfg_period = 16'd2; cfg_num = 8'd0; start = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      p = (k - 1) % 2;
      exp_q.push_back(mk(1'b1, p == 0, p == 0, 1'b0, 1'b0, 8'(((k - 1) / 2) % 256)));
      tick();
      start = 1'b0;
      ex = exp_q.pop_front();
      got = obs();
      n_checks++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL continuous k=%0d got=%b required=%b", k, got, ex);
      end
    end
    stop = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
      tick();
      stop = 1'b0;
      ex = exp_q.pop_front();
      got = obs();
      n_checks++;
      if (got[12:8] !== ex[12:8]) begin
        n_fail++;
        $display("FAIL continuous_stop k=%0d got=%b required=%b", k, got[12:8], ex[12:8]);
      end
    end
  endtask

  // cfg changes and repeated start while busy, plus a start during FINISH
  task automatic test_back_to_back();
    vec_t ex, got;
    int   p;
    cfg_on = 16'd2; cfg_period = 16'd4; cfg_num = 8'd3; start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      p = (k - 1) % 4;
      if (k <= 12) exp_q.push_back(mk(1'b1, p < 2, p == 0, 1'b0, 1'b0, 8'((k - 1) / 4)));
      else         exp_q.push_back(mk(1'b0, 1'b0, 1'b0, k == 13, 1'b0, 8'd2));
      tick();
      ex = exp_q.pop_front();
      got = obs();
      n_checks++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL back_to_back k=%0d got=%b required=%b", k, got, ex);
      end
      if (k >= 2 && k <= 13) begin
        start = 1'b1; cfg_on = 16'd1; cfg_period = 16'd8; cfg_num = 8'd5;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_mid_reset();
    vec_t ex, got;
    int   p;
    cfg_on = 16'd3; cfg_period = 16'd10; cfg_num = 8'd3;
    for (int pass = 0; pass < 2; pass++) begin
      start = 1'b1;
      for (int k = 1; k <= 12; k++) begin
        p = (k - 1) % 10;
        exp_q.push_back(mk(1'b1, p < 3, p == 0, 1'b0, 1'b0, 8'((k - 1) / 10)));
        tick();
        start = 1'b0;
        ex = exp_q.pop_front();
        got = obs();
        n_checks++;
        if (got !== ex) begin
          n_fail++;
          $display("FAIL mid_reset pass=%0d k=%0d got=%b required=%b", pass, k, got, ex);
        end
      end
      if (pass == 0) rst = 1'b0;
      else           stop = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
      tick();
      rst = 1'b1; stop = 1'b0;
      ex = exp_q.pop_front();
      got = obs();
      n_checks++;
      if ((pass == 0) ? (got !== ex) : (got[12:8] !== ex[12:8])) begin
        n_fail++;
        $display("FAIL mid_reset_end pass=%0d got=%b required=%b", pass, got, ex);
      end
    end
  endtask

`ifdef PULSE_SYNC_EN
  task automatic test_sync();
    vec_t ex, got;
    int   p;
    sync_in = 1'b0;
    cfg_on = 16'd2; cfg_period = 16'd4; cfg_num = 8'd1; start = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      p = k - 8;
      if (k <= 7)       exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
      else if (k <= 11) exp_q.push_back(mk(1'b1, p < 2, p == 0, 1'b0, 1'b0, 8'd0));
      else              exp_q.push_back(mk(1'b0, 1'b0, 1'b0, k == 12, 1'b0, 8'd0));
      tick();
      start = 1'b0;
      ex = exp_q.pop_front();
      got = obs();
      n_checks++;
      if ((k <= 7) ? (got[12:8] !== ex[12:8]) : (got !== ex)) begin
        n_fail++;
        $display("FAIL sync k=%0d got=%b required=%b", k, got, ex);
      end
      if (k == 7) sync_in = 1'b1;
    end
    sync_in = 1'b0;
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(mk(k <= 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
      tick();
      start = 1'b0;
      stop = (k == 3);
      ex = exp_q.pop_front();
      got = obs();
      n_checks++;
      if (got[12:8] !== ex[12:8]) begin
        n_fail++;
        $display("FAIL sync_stop k=%0d got=%b required=%b", k, got[12:8], ex[12:8]);
      end
    end
    stop = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; sync_in = 1'b0;
    cfg_on = '0; cfg_period = '0; cfg_num = '0;
    #2;
    test_reset();
    test_basic_burst();
    test_cfg_err();
    test_continuous();
    test_back_to_back();
    test_mid_reset();
`ifdef PULSE_SYNC_EN
    test_sync();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_burst_ctrl.md
Name: pulse_burst_ctrl

Overview:
Programmable pulse-burst scheduler that sequences the transmit gate for the BPSK sine datapath. It generalises the fixed 20 us / 100 us pulse: on-time, period and pulse count are loaded per burst through a start/busy handshake. Outputs are the gate that enables the modulator, per-pulse strobes for downstream framing, and burst-completion status.

Parameters:
CNT_W, 16, width of on-time, period and in-period counter
NUM_W, 8, width of pulse-count config and pulse index

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
start  in  1  burst request; sampled only in IDLE
stop  in  1  abort request; sampled in every state
cfg_on  in  CNT_W  gate-high cycles per pulse
cfg_period  in  CNT_W  cycles per pulse period
cfg_num  in  NUM_W  pulses per burst; 0 = continuous until stop
busy  out  1  burst in progress
gate  out  1  modulator enable, registered
pulse_start  out  1  one-cycle strobe, coincident with first gate-high cycle of each pulse
pulse_idx  out  NUM_W  0-based index of current pulse
done  out  1  one-cycle strobe, burst completed normally
cfg_err  out  1  one-cycle strobe, start rejected for illegal config

Behaviour:
- Reset (rst=0 at an edge): state IDLE; busy, gate, pulse_start, done, cfg_err = 0; pulse_idx = 0; internal counters = 0. Applies mid-burst; a burst is never resumed.
- States: IDLE, ARM (only with macro), RUN, FINISH.
- IDLE with start=1, stop=0:
  - Latches cfg_on, cfg_period and cfg_num. Later config changes have no effect until the next start.
  - Illegal config (cfg_on==0, or cfg_on>=cfg_period): cfg_err=1 for one cycle; stays IDLE; busy stays 0.
  - Legal config: enters RUN at the same edge. Next cycle shows busy=1, gate=1, pulse_start=1, pulse_idx=0, phase counter=0.
  - Latency is therefore 1 cycle from the start sample to the first gate-high cycle.
- IDLE with start and stop both 1: stop wins. Nothing is latched and no strobe is issued.
- RUN, phase counter p counts 0..period-1:
  - gate=1 for p < on, else 0. Each pulse gives exactly cfg_on gate-high cycles per cfg_period cycles.
  - When p==period-1, p wraps to 0 and the pulse count increments.
  - If pulses completed == cfg_num (cfg_num != 0), next state is FINISH.
  - Otherwise pulse_idx increments (wraps modulo 2^NUM_W when continuous), and pulse_start=1 with gate=1 in the next cycle.
- FINISH: lasts one cycle. done=1, busy=0, gate=0. Then IDLE, where pulse_idx holds its last value.
- stop=1 in RUN or ARM: at that edge returns to IDLE. The next cycle shows gate=0 and busy=0; done is not asserted; a partial pulse is truncated.
- start while busy: ignored, with no error strobe.
- A start in FINISH is ignored; start is accepted from IDLE only.
- Arithmetic: counters are CNT_W bits unsigned. The illegal-config check guarantees the compare never wraps. Pulse count is NUM_W bits.

Optional Feature:
PULSE_SYNC_EN
- Defined:
  - Adds input port sync_in (1 bit, already synchronous to clk).
  - A legal start enters ARM instead of RUN, with busy=1 and gate=0.
  - ARM waits for a rising edge of sync_in, detected against a registered copy of sync_in. The cycle after the detected edge shows gate=1, pulse_start=1, pulse_idx=0.
  - stop in ARM aborts to IDLE.
- Undefined: no sync_in port, no ARM state; RUN is entered directly as above.

Test Plan:
1. cfg_on=3, cfg_period=10, cfg_num=2, start one cycle -> gate high cycles 1-3 and 11-13 after start; pulse_start at cycles 1 and 11; pulse_idx 0 then 1; done=1 at cycle 21, busy low from cycle 21.
2. cfg_on=10, cfg_period=10 (also cfg_on=0) -> cfg_err one cycle, busy/gate stay 0.
3. cfg_num=0, cfg_on=1, cfg_period=2, NUM_W=8, run 600 cycles -> gate toggles every cycle, pulse_idx wraps 255->0, no done; stop -> gate/busy 0 next cycle, no done.
4. Start with cfg_on=2, cfg_period=4; change cfg inputs mid-burst; assert start again while busy -> timing unchanged, second start ignored.
5. rst=0 during gate-high of pulse 1 -> all outputs 0 next cycle; start after release -> fresh burst at pulse_idx 0.
6. PULSE_SYNC_EN, start then sync_in rising 7 cycles later -> busy=1, gate=0 for 7 cycles, first gate/pulse_start the cycle after the edge is detected; stop during ARM -> IDLE, no done.
